nabp_image_ram_banked: RTL and testbench

//  Multi-channel, banked image accumulator RAM for the NABP simulator.
//  NUM_CH processing-element channels each own one bank of 2**ADDR_W pixels.

---
 rtl/nabp_image_ram_banked.sv | 188 ++++++++++++++++++
 tb/tb_nabp_image_ram_banked.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nabp_image_ram_banked.sv
// ---------------------------------------------------------------------------
// nabp_image_ram_banked
//   Banked image accumulator RAM. Each of NUM_CH channels owns one bank of
//   2**ADDR_W signed pixels and performs read-modify-write accumulation of its
//   signed samples. A frame is clear -> accumulate -> drain -> stream out.
//
// Ports
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   ir_kick               start a frame (IDLE only)
//   ir_done               end accumulation (ACCUM only)
//   ir_valid/addr/val     per-channel write strobe, pixel address, signed sample
//                         (channel c packed at [c*W +: W])
//   ir_enable             high while samples are accepted (ACCUM)
//   ro_valid/ready        readout handshake
//   ro_addr/data/last     {bank, pixel}, accumulated value, final-word flag
//   ovf                   sticky saturation/wrap flag, cleared by accepted kick
// ---------------------------------------------------------------------------
module nabp_image_ram_banked #(
    parameter int NUM_CH   = 4,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 24,
    parameter bit SATURATE = 1'b1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             ir_kick,
    input  logic                             ir_done,
    input  logic [NUM_CH-1:0]                ir_valid,
    input  logic [NUM_CH*ADDR_W-1:0]         ir_addr,
    input  logic [NUM_CH*DATA_W-1:0]         ir_val,
    output logic                             ir_enable,
    output logic                             ro_valid,
    input  logic                             ro_ready,
    output logic [$clog2(NUM_CH)+ADDR_W-1:0] ro_addr,
    output logic [ACC_W-1:0]                 ro_data,
    output logic                             ro_last,
    output logic                             ovf
);
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int RA_W   = $clog2(NUM_CH) + ADDR_W;
    localparam int BANK_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ACCUM, S_DRAIN, S_READOUT} state_t;

    state_t                       state_q;
    logic [ADDR_W-1:0]            clr_q;
    logic [NUM_CH-1:0]            s1_v_q;     // stage-1 request valid (read issued)
    logic [NUM_CH-1:0]            lw_v_q;     // a write landed on the last edge
    logic [NUM_CH-1:0]            wr_ovf;
    logic                         en_q, ro_valid_q, ro_last_q, ovf_q;
    logic [RA_W-1:0]              ro_addr_q, ro_addr_d;
    logic [ACC_W-1:0]             ro_data_q;
    logic [NUM_CH-1:0][ACC_W-1:0] bank_rd;
    logic [BANK_W-1:0]            rd_bank;
    logic [ADDR_W-1:0]            rd_pix;

    // Readout address for the word loaded on the next transfer; the first word
    // is loaded on the DRAIN -> READOUT edge from address zero.
    always_comb begin
        ro_addr_d = (state_q == S_READOUT) ? ro_addr_q + RA_W'(1) : '0;
        rd_pix    = ro_addr_d[ADDR_W-1:0];
        rd_bank   = BANK_W'(ro_addr_d >> ADDR_W);
    end

    // Per-bank two-stage RMW: stage 1 registers the request and the RAM read,
    // stage 2 adds and writes. The only write the stage-1 read can miss is the
    // one committed on the same edge, so a single forwarding register suffices.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_bank
        logic [ACC_W-1:0]  mem [DEPTH];
        logic [ADDR_W-1:0] s1_a_q, lw_a_q;
        logic [DATA_W-1:0] s1_x_q;
        logic [ACC_W-1:0]  s1_rd_q, lw_d_q, base, wr_d;
        logic [ACC_W:0]    sum;
        logic              sum_ovf;

        // NOTE: every variable gets a value on every path through always_comb,
        // otherwise a latch is inferred.
        always_comb begin
            base    = (lw_v_q[c] && (lw_a_q == s1_a_q)) ? lw_d_q : s1_rd_q;
            sum     = {base[ACC_W-1], base}
                    + {{(ACC_W+1-DATA_W){s1_x_q[DATA_W-1]}}, s1_x_q};
            sum_ovf = s1_v_q[c] && (sum[ACC_W] != sum[ACC_W-1]);
            wr_d    = sum[ACC_W-1:0];
            if (SATURATE && sum_ovf) begin
                wr_d = sum[ACC_W] ? ACC_MIN : ACC_MAX;
            end
        end

        // NOTE: RAM and datapath registers carry no reset; CLEAR initialises the
        // array and the valid bits in the reset domain qualify the datapath.
        always_ff @(posedge clk) begin
            if (state_q == S_CLEAR) begin
                mem[clr_q] <= '0;
            end else if (s1_v_q[c]) begin
                mem[s1_a_q] <= wr_d;
            end
            s1_rd_q <= mem[ir_addr[c*ADDR_W +: ADDR_W]];
            s1_a_q  <= ir_addr[c*ADDR_W +: ADDR_W];
            s1_x_q  <= ir_val[c*DATA_W +: DATA_W];
            lw_a_q  <= s1_a_q;
            lw_d_q  <= wr_d;
        end

        assign wr_ovf[c]  = sum_ovf;
        assign bank_rd[c] = mem[rd_pix];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            clr_q      <= '0;
            s1_v_q     <= '0;
            lw_v_q     <= '0;
            en_q       <= 1'b0;
            ro_valid_q <= 1'b0;
            ro_addr_q  <= '0;
            ro_data_q  <= '0;
            ro_last_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every right-hand
            // side reads the pre-edge value regardless of statement order.
            lw_v_q <= s1_v_q;
            s1_v_q <= (state_q == S_ACCUM) ? ir_valid : '0;
            if (|wr_ovf) begin
                ovf_q <= 1'b1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (ir_kick) begin
                        state_q <= S_CLEAR;
                        clr_q   <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    clr_q <= clr_q + ADDR_W'(1);
                    if (clr_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= S_ACCUM;
                        en_q    <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (ir_done) begin
                        state_q <= S_DRAIN;
                        en_q    <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    // Leave only once no stage-2 write commits on this edge, so
                    // the first readout word sees the final RAM contents.
                    if (s1_v_q == '0) begin
                        state_q    <= S_READOUT;
                        ro_valid_q <= 1'b1;
                        ro_addr_q  <= ro_addr_d;
                        ro_data_q  <= bank_rd[rd_bank];
                        ro_last_q  <= &ro_addr_d;
                    end
                end
                S_READOUT: begin
                    if (ro_ready) begin
                        if (ro_last_q) begin
                            state_q    <= S_IDLE;
                            ro_valid_q <= 1'b0;
                            ro_last_q  <= 1'b0;
                        end else begin
                            ro_addr_q <= ro_addr_d;
                            ro_data_q <= bank_rd[rd_bank];
                            ro_last_q <= &ro_addr_d;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ir_enable = en_q;
    assign ro_valid  = ro_valid_q;
    assign ro_addr   = ro_addr_q;
    assign ro_data   = ro_data_q;
    assign ro_last   = ro_last_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_nabp_image_ram_banked.sv
// ---------------------------------------------------------------------------
// tb_nabp_image_ram_banked
//   Randomised frames against a behavioural accumulator model (plain arrays,
//   writes applied immediately with saturating arithmetic). A negedge monitor
//   checks every readout transfer and stall stability against the model.
// ---------------------------------------------------------------------------
module tb_nabp_image_ram_banked;
    localparam int NUM_CH = 4;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 24;
    localparam bit SAT    = 1'b1;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int WORDS  = NUM_CH * DEPTH;
    localparam int RA_W   = $clog2(NUM_CH) + ADDR_W;
    localparam longint MAXV = (longint'(1) <<< (ACC_W - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (ACC_W - 1));

    logic                      clk = 1'b0;
    logic                      reset_n = 1'b0;
    logic                      ir_kick = 1'b0;
    logic                      ir_done = 1'b0;
    logic [NUM_CH-1:0]         ir_valid = '0;
    logic [NUM_CH*ADDR_W-1:0]  ir_addr = '0;
    logic [NUM_CH*DATA_W-1:0]  ir_val = '0;
    logic                      ro_ready = 1'b0;
    logic                      ir_enable, ro_valid, ro_last, ovf;
    logic [RA_W-1:0]           ro_addr;
    logic [ACC_W-1:0]          ro_data;

    nabp_image_ram_banked #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_W(ACC_W), .SATURATE(SAT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ir_kick(ir_kick), .ir_done(ir_done),
        .ir_valid(ir_valid), .ir_addr(ir_addr), .ir_val(ir_val),
        .ir_enable(ir_enable), .ro_valid(ro_valid), .ro_ready(ro_ready),
        .ro_addr(ro_addr), .ro_data(ro_data), .ro_last(ro_last), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint mm [NUM_CH][DEPTH];
    bit     ovf_m = 1'b0;

    function automatic void model_write(input int c, input int a, input longint x);
        longint s;
        s = mm[c][a] + x;
        if (s > MAXV) begin
            ovf_m = 1'b1;
            s = SAT ? MAXV : s - (longint'(1) <<< ACC_W);
        end else if (s < MINV) begin
            ovf_m = 1'b1;
            s = SAT ? MINV : s + (longint'(1) <<< ACC_W);
        end
        mm[c][a] = s;
    endfunction

    function automatic longint sdata(input logic [ACC_W-1:0] d);
        logic signed [ACC_W-1:0] s;
        s = d;
        return longint'(s);
    endfunction

    // ---------------- readout monitor ----------------
    int              exp_idx = 0;
    int              n_xfer = 0;
    int              first_cyc = 0;
    int              last_cyc = 0;
    bit              first_seen = 1'b0;
    bit              stall_prev = 1'b0;
    logic [RA_W-1:0] hold_addr;
    logic [ACC_W-1:0] hold_data;
    logic            hold_last;
    longint          rd_buf [WORDS];

    always @(negedge clk) begin
        if (!reset_n) begin
            stall_prev = 1'b0;
        end else if (ro_valid) begin
            if (!first_seen) begin
                first_seen = 1'b1;
                first_cyc  = cyc;
            end
            if (stall_prev) begin
                check("stall_addr", longint'(ro_addr), longint'(hold_addr));
                check("stall_data", sdata(ro_data), sdata(hold_data));
                check("stall_last", longint'(ro_last), longint'(hold_last));
            end
            if (ro_ready) begin
                check("ro_addr", longint'(ro_addr), exp_idx);
                check("ro_last", longint'(ro_last), longint'(exp_idx == WORDS - 1));
                if (exp_idx < WORDS) begin
                    check("ro_data", sdata(ro_data), mm[exp_idx / DEPTH][exp_idx % DEPTH]);
                    rd_buf[exp_idx] = sdata(ro_data);
                end
                exp_idx++;
                n_xfer++;
                last_cyc = cyc;
            end
            stall_prev = !ro_ready;
            hold_addr  = ro_addr;
            hold_data  = ro_data;
            hold_last  = ro_last;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        ir_valid = '0;
        ir_kick  = 1'b0;
        ir_done  = 1'b0;
    endtask

    function automatic int rand_val();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic drive_ch(input int c, input int a, input int x, input bit modelled);
        logic [ADDR_W-1:0] a_b;
        logic [DATA_W-1:0] x_b;
        a_b = ADDR_W'(a);
        x_b = DATA_W'(x);
        ir_valid[c] = 1'b1;
        ir_addr[c*ADDR_W +: ADDR_W] = a_b;
        ir_val[c*DATA_W +: DATA_W]  = x_b;
        if (modelled) model_write(c, a, longint'(x));
    endtask

    // Kick, then hold done/valid noise through CLEAR; ir_enable must rise
    // exactly DEPTH+1 cycles after the kick cycle.
    task automatic start_frame();
        ir_kick = 1'b1;
        tick();
        ir_kick = 1'b0;
        for (int c = 0; c < NUM_CH; c++)
            for (int a = 0; a < DEPTH; a++) mm[c][a] = 0;
        ovf_m = 1'b0;
        check("kick_clears_ovf", longint'(ovf), 0);
        check("enable_low_after_kick", longint'(ir_enable), 0);
        for (int i = 0; i < DEPTH - 1; i++) begin
            quiet();
            ir_done = 1'($urandom_range(0, 1));
            for (int c = 0; c < NUM_CH; c++)
                if ($urandom_range(0, 1) == 1) drive_ch(c, int'($urandom_range(0, DEPTH - 1)), rand_val(), 1'b0);
            tick();
        end
        quiet();
        check("enable_low_before_latency", longint'(ir_enable), 0);
        tick();
        check("enable_high_at_latency", longint'(ir_enable), 1);
    endtask

    task automatic end_accum();
        ir_done = 1'b1;
        tick();
        quiet();
        check("enable_drops_after_done", longint'(ir_enable), 0);
    endtask

    task automatic readout(input bit rand_ready);
        int guard;
        guard = 0;
        exp_idx = 0;
        n_xfer = 0;
        first_seen = 1'b0;
        while (n_xfer < WORDS && guard < 20000) begin
            quiet();
            ro_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rand_ready) begin
                ir_kick = 1'($urandom_range(0, 1));
                ir_done = 1'($urandom_range(0, 1));
                for (int c = 0; c < NUM_CH; c++)
                    if ($urandom_range(0, 1) == 1) drive_ch(c, int'($urandom_range(0, DEPTH - 1)), rand_val(), 1'b0);
            end
            tick();
            guard++;
        end
        quiet();
        ro_ready = 1'b0;
        check("readout_count", n_xfer, WORDS);
        check("ro_valid_low_after_last", longint'(ro_valid), 0);
        check("frame_ovf", longint'(ovf), longint'(ovf_m));
        if (!rand_ready) check("no_bubbles", longint'(last_cyc - first_cyc), WORDS - 1);
        repeat (3) tick();
        check("idle_after_frame", longint'(ir_enable), 0);
        check("no_valid_in_idle", longint'(ro_valid), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int t3_vals [4] = '{1, 2, 3, -10};

        // Power-on reset
        reset_n = 1'b0;
        tick();
        tick();
        check("rst_ir_enable", longint'(ir_enable), 0);
        check("rst_ro_valid", longint'(ro_valid), 0);
        check("rst_ro_last", longint'(ro_last), 0);
        check("rst_ovf", longint'(ovf), 0);
        check("rst_ro_data", longint'(ro_data), 0);
        check("rst_ro_addr", longint'(ro_addr), 0);
        reset_n = 1'b1;
        tick();

        // T1: saturate, then reset mid-ACCUM
        start_frame();
        for (int i = 0; i < 300; i++) begin
            drive_ch(1, 0, 32767, 1'b1);
            tick();
            quiet();
        end
        tick();
        tick();
        check("t1_ovf_before_reset", longint'(ovf), 1);
        reset_n = 1'b0;
        #2;
        check("t1_rst_ir_enable", longint'(ir_enable), 0);
        check("t1_rst_ro_valid", longint'(ro_valid), 0);
        check("t1_rst_ovf", longint'(ovf), 0);
        tick();
        reset_n = 1'b1;
        tick();
        check("t1_idle_after_reset", longint'(ir_enable), 0);

        // T2: single write in the done cycle, ready held high
        start_frame();
        drive_ch(2, 5, 7, 1'b1);
        end_accum();
        readout(1'b0);
        check("t2_word_517", rd_buf[2 * DEPTH + 5], 7);
        check("t2_word_516", rd_buf[2 * DEPTH + 4], 0);
        check("t2_word_256", rd_buf[DEPTH], 0);

        // T3/T4/T5/T6: hazards, saturation, random traffic, backpressure, noise
        start_frame();
        for (int i = 0; i < 4; i++) begin
            drive_ch(0, 9, t3_vals[i], 1'b1);
            tick();
            quiet();
        end
        for (int i = 0; i < 4; i++) begin
            drive_ch(0, 10, t3_vals[i], 1'b1);
            tick();
            quiet();
            tick();
        end
        for (int i = 0; i < 300; i++) begin
            drive_ch(1, 0, 32767, 1'b1);
            tick();
            quiet();
        end
        for (int i = 0; i < 200; i++) begin
            ir_kick = 1'($urandom_range(0, 1));
            for (int c = 0; c < NUM_CH; c++)
                if ($urandom_range(0, 1) == 1) drive_ch(c, 16 + int'($urandom_range(0, 7)), rand_val(), 1'b1);
            tick();
            quiet();
        end
        for (int c = 0; c < NUM_CH; c++) drive_ch(c, 16 + int'($urandom_range(0, 7)), rand_val(), 1'b1);
        end_accum();
        readout(1'b1);
        check("t3_b2b_addr9", rd_buf[9], -4);
        check("t3_gap_addr10", rd_buf[10], -4);
        check("t4_sat_value", rd_buf[DEPTH], 8388607);
        check("t4_ovf_sticky", longint'(ovf), 1);

        // Second frame: only its own writes, ready held high
        start_frame();
        for (int i = 0; i < 150; i++) begin
            for (int c = 0; c < NUM_CH; c++)
                if ($urandom_range(0, 1) == 1)
                    drive_ch(c, ($urandom_range(0, 1) == 1) ? 100 + int'($urandom_range(0, 3))
                                                            : 100 + int'($urandom_range(0, 155)),
                             rand_val(), 1'b1);
            tick();
            quiet();
        end
        end_accum();
        readout(1'b0);
        check("t6_old_addr9_gone", rd_buf[9], 0);
        check("t6_old_sat_gone", rd_buf[DEPTH], 0);
        check("t6_no_ovf", longint'(ovf), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
